jam_sequencer: RTL
==================

Name: jam_sequencer

Overview:
- Controller that sequences the jam-operation unit. It qualifies jam sensor activity and negotiates a hand-over with the normal-mode controller over a req/ack pair.
- Drives jam_op_en, jam_start and jam_rotation to the jam unit. Returns control once all roads stay clear.
- Sits between the four jam sensors, the normal-mode controller and the jam unit.

Parameters:
- DETECT_CYCLES, 8: consecutive cycles with any sensor high needed to qualify a jam.
- GREEN_CYCLES, 16: cycles each road is served before a rotation pulse.
- CLEAR_CYCLES, 8: consecutive all-clear cycles needed to end jam mode.
- ALL_RED_CYCLES, 4: cycles with jam_op_en low before control returns to normal mode.
- CNT_W, 8: width of the internal counters. Every cycle-count parameter must be ≥1 and below 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- jam_enable  in  1  configuration enable for jam handling.
- jam_sensor_0..jam_sensor_3  in  1 each  per-road jam sensors.
- normal_ack  in  1  normal-mode controller reports it is parked all-red.
- jam_req  out  1  request/hold for the normal-mode controller to park.
- jam_op_en  out  1  enable to the jam unit.
- jam_start  out  1  one-cycle start pulse to the jam unit.
- jam_rotation  out  1  one-cycle rotate pulse to the jam unit.
- jam_mode  out  1  high in START and SERVE.
- rotation_count  out  CNT_W  rotations issued in the current jam episode, saturating.

Behaviour:
- Reset:
  - Applies while rst=1 at a clk edge. Valid in any state, including mid-episode.
  - state=NORMAL; all outputs 0; detect/green/clear/drain counters 0.
- Timing: all outputs are registered. any_jam = OR of the four sensors, sampled at each edge.
- NORMAL:
  - jam_req=0, jam_op_en=0.
  - detect_cnt increments at each edge where any_jam=1 and jam_enable=1; otherwise it clears to 0.
  - At the edge where any_jam has been sampled 1 on DETECT_CYCLES consecutive edges, go to REQ (jam_req=1 from that edge).
  - detect_cnt clears on entry to NORMAL.
- REQ:
  - jam_req=1; wait for normal_ack.
  - If jam_enable=0, or any_jam=0 on that edge, go to NORMAL (jam_req drops).
  - If normal_ack=1, go to START.
  - If both an abort condition and normal_ack=1 occur on the same edge, abort wins.
- START (exactly 1 cycle):
  - jam_op_en=1, jam_start=1.
  - green_cnt=0, clear_cnt=0, rotation_count=0.
  - Next edge: SERVE.
- SERVE:
  - jam_op_en=1, jam_req=1, jam_start=0.
  - green_cnt increments each edge. When it reaches GREEN_CYCLES-1: pulse jam_rotation for one cycle, green_cnt returns to 0, rotation_count+1 (saturates at all-ones).
  - Result: first jam_rotation high exactly GREEN_CYCLES cycles after jam_start was high, then every GREEN_CYCLES cycles.
  - clear_cnt increments on each edge with any_jam=0 and clears on any_jam=1.
  - On CLEAR_CYCLES consecutive clear samples, go to DRAIN.
  - jam_enable=0 sampled: go to DRAIN immediately.
  - If exit and rotation fall on the same edge, exit wins and no rotation pulse is issued.
  - normal_ack dropping during SERVE is ignored.
- DRAIN:
  - jam_op_en=0, so the jam unit clears all allows. jam_req stays 1 so normal mode stays parked.
  - Lasts ALL_RED_CYCLES cycles, then NORMAL with jam_req=0.
  - Sensor activity is ignored; detection restarts from 0 in NORMAL.
- rotation_count holds its value from the end of the episode until the next START.
- Unused state encodings recover to NORMAL with outputs 0.

Test Plan:
- Reset: rst=1 for 2 cycles in each state (NORMAL, REQ, SERVE, DRAIN) -> all outputs 0 and state NORMAL on the next cycle.
- Qualify:
  - jam_enable=1, sensor_2 held high, normal_ack tied 1 -> jam_req rises at the 8th sampling edge.
  - jam_op_en and jam_start are both high for the next 1 cycle.
  - jam_rotation pulses 16, 32 and 48 cycles after jam_start; rotation_count reads 1, 2, 3.
- Glitch filter: sensor_1 high for 7 cycles, low 1 cycle, high 7 cycles -> jam_req stays 0 throughout.
- Hand-over:
  - jam qualified, normal_ack held 0 for 10 cycles, then 1 -> jam_start only after ack, jam_req held high while waiting.
  - Variant: sensors drop while waiting in REQ -> return to NORMAL, no jam_start.
- Exit:
  - In SERVE, all sensors low for 8 cycles -> jam_op_en falls.
  - jam_req falls exactly 4 cycles later, with no further jam_rotation.
  - Variant: the clear completes on the same edge as a rotation -> no jam_rotation pulse.
- Disable mid-episode: jam_enable dropped during SERVE -> next cycle jam_op_en=0; 4 cycles later jam_req=0, jam_mode=0.

Source files
------------

// File: rtl/jam_sequencer.sv
// Jam-operation sequencer: qualifies jam sensor activity, negotiates the
// hand-over with the normal-mode controller over jam_req/normal_ack, drives
// the jam unit (enable, start, rotate) and returns control once all roads
// have stayed clear, passing through an all-red drain interval.
module jam_sequencer #(
   parameter int DETECT_CYCLES  = 8,
   parameter int GREEN_CYCLES   = 16,
   parameter int CLEAR_CYCLES   = 8,
   parameter int ALL_RED_CYCLES = 4,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             jam_enable,
   input  logic             jam_sensor_0,
   input  logic             jam_sensor_1,
   input  logic             jam_sensor_2,
   input  logic             jam_sensor_3,
   input  logic             normal_ack,
   output logic             jam_req,
   output logic             jam_op_en,
   output logic             jam_start,
   output logic             jam_rotation,
   output logic             jam_mode,
   output logic [CNT_W-1:0] rotation_count
);

   typedef enum logic [2:0] {
      S_NORMAL = 3'd0,
      S_REQ    = 3'd1,
      S_START  = 3'd2,
      S_SERVE  = 3'd3,
      S_DRAIN  = 3'd4
   } state_t;

   // Terminal values of the counters: each counter runs 0..LAST.
   localparam logic [CNT_W-1:0] DET_LAST = CNT_W'(DETECT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GRN_LAST = CNT_W'(GREEN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] RED_LAST = CNT_W'(ALL_RED_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] detect_cnt;
   logic [CNT_W-1:0] green_cnt;
   logic [CNT_W-1:0] clear_cnt;
   logic [CNT_W-1:0] drain_cnt;
   logic             any_jam;
   logic             green_wrap;
   logic             serve_exit;

   // Saturating increment: the rotation counter sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Sensor OR plus the green-period wrap and serve-exit decisions.
   always_comb begin
      any_jam    = jam_sensor_0 | jam_sensor_1 | jam_sensor_2 | jam_sensor_3;
      green_wrap = (green_cnt == GRN_LAST);
      // Exit has priority over a rotation landing on the same edge.
      serve_exit = !jam_enable || (!any_jam && (clear_cnt == CLR_LAST));
   end

   // Sequencer FSM with registered outputs and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_NORMAL;
         jam_req        <= 1'b0;
         jam_op_en      <= 1'b0;
         jam_start      <= 1'b0;
         jam_rotation   <= 1'b0;
         jam_mode       <= 1'b0;
         rotation_count <= '0;
         detect_cnt     <= '0;
         green_cnt      <= '0;
         clear_cnt      <= '0;
         drain_cnt      <= '0;
      end else begin
         jam_start    <= 1'b0;
         jam_rotation <= 1'b0;
         case (state)
            S_NORMAL: begin
               jam_req   <= 1'b0;
               jam_op_en <= 1'b0;
               jam_mode  <= 1'b0;
               if (any_jam && jam_enable) begin
                  if (detect_cnt == DET_LAST) begin
                     state      <= S_REQ;
                     jam_req    <= 1'b1;
                     detect_cnt <= '0;
                  end else begin
                     detect_cnt <= detect_cnt + CNT_W'(1);
                  end
               end else begin
                  detect_cnt <= '0;
               end
            end
            S_REQ: begin
               // Abort beats an acknowledge on the same edge.
               if (!jam_enable || !any_jam) begin
                  state      <= S_NORMAL;
                  jam_req    <= 1'b0;
                  detect_cnt <= '0;
               end else if (normal_ack) begin
                  state          <= S_START;
                  jam_op_en      <= 1'b1;
                  jam_start      <= 1'b1;
                  jam_mode       <= 1'b1;
                  green_cnt      <= '0;
                  clear_cnt      <= '0;
                  rotation_count <= '0;
               end
            end
            S_START: begin
               // The start cycle already counts toward the first green period.
               state <= S_SERVE;
               if (green_wrap) begin
                  green_cnt      <= '0;
                  jam_rotation   <= 1'b1;
                  rotation_count <= sat_inc(rotation_count);
               end else begin
                  green_cnt <= green_cnt + CNT_W'(1);
               end
            end
            S_SERVE: begin
               if (serve_exit) begin
                  state     <= S_DRAIN;
                  jam_op_en <= 1'b0;
                  jam_mode  <= 1'b0;
                  drain_cnt <= '0;
               end else begin
                  if (green_wrap) begin
                     green_cnt      <= '0;
                     jam_rotation   <= 1'b1;
                     rotation_count <= sat_inc(rotation_count);
                  end else begin
                     green_cnt <= green_cnt + CNT_W'(1);
                  end
                  clear_cnt <= any_jam ? '0 : clear_cnt + CNT_W'(1);
               end
            end
            S_DRAIN: begin
               // jam_req stays high so the normal controller remains parked.
               if (drain_cnt == RED_LAST) begin
                  state      <= S_NORMAL;
                  jam_req    <= 1'b0;
                  drain_cnt  <= '0;
                  detect_cnt <= '0;
               end else begin
                  drain_cnt <= drain_cnt + CNT_W'(1);
               end
            end
            default: begin
               state          <= S_NORMAL;
               jam_req        <= 1'b0;
               jam_op_en      <= 1'b0;
               jam_mode       <= 1'b0;
               rotation_count <= '0;
               detect_cnt     <= '0;
               green_cnt      <= '0;
               clear_cnt      <= '0;
               drain_cnt      <= '0;
            end
         endcase
      end
   end

endmodule
